regfile_write_arbiter: RTL

// - Shares the single register-file write port (A3/WD3/WE3) among N_REQ writeback sources.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/regfile_write_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-command classification used by
// the writeback arbiter.
package regfile_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int N_REG   = 16;
    localparam int PC_ADDR = 15;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_REG  = 2'd1,
        WR_PC   = 2'd2
    } wr_kind_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, rotating pointer advanced
// past each granted source.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);
    import regfile_pkg::*;

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] sel;
    logic          found;
    logic [N-1:0]  gnt;
    logic [PW:0]   sum;
    logic [PW:0]   nxt;

    // Search starts at ptr_q and wraps modulo N; first requester wins.
    always_comb begin
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            if (!found && req_i[sum[PW-1:0]]) begin
                found = 1'b1;
                sel   = sum[PW-1:0];
            end
        end
        if (found && en_i && !rst_i) begin
            gnt[sel] = 1'b1;
        end
    end

    always_comb begin
        nxt   = {1'b0, sel} + (PW+1)'(1);
        ptr_d = ptr_q;
        if (found && en_i) begin
            ptr_d = (nxt == (PW+1)'(N)) ? '0 : nxt[PW-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among N_REQ writeback sources; writes to
// the PC address are diverted to a separate PC update strobe.
module regfile_write_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int PC_ADDR = regfile_pkg::PC_ADDR,
    parameter int CNT_W   = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         REQ,
    input  logic [N_REQ*ADDR_W-1:0]  ADDR,
    input  logic [N_REQ*DATA_W-1:0]  DATA,
    input  logic                     HOLD,
    output logic [N_REQ-1:0]         GNT,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic                     WE3,
    output logic                     PC_WE,
    output logic [DATA_W-1:0]        PC_WD,
    output logic [CNT_W-1:0]         CONFLICTS
);
    import regfile_pkg::*;

    function automatic logic multi_req(input logic [N_REQ-1:0] r);
        return (r & (r - N_REQ'(1))) != '0;
    endfunction

    logic [N_REQ-1:0]  gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    wr_kind_e          kind;

    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic              pc_we_q, pc_we_d;
    logic [DATA_W-1:0] pc_wd_q, pc_wd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk_i (CLK),
        .rst_i (RST),
        .req_i (REQ),
        .en_i  (~HOLD),
        .gnt_o (gnt)
    );

    // Grant is one-hot, so an OR-mux selects the winning source's payload.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | ADDR[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | DATA[i*DATA_W +: DATA_W];
            end
        end
        if (gnt == '0) begin
            kind = WR_NONE;
        end else if (sel_addr == ADDR_W'(PC_ADDR)) begin
            kind = WR_PC;
        end else begin
            kind = WR_REG;
        end
    end

    always_comb begin
        we3_d   = (kind == WR_REG);
        a3_d    = (kind == WR_REG) ? sel_addr : a3_q;
        wd3_d   = (kind == WR_REG) ? sel_data : wd3_q;
        pc_we_d = (kind == WR_PC);
        pc_wd_d = (kind == WR_PC) ? sel_data : pc_wd_q;
        cnt_d   = cnt_q;
        if (!HOLD && multi_req(REQ) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we3_q   <= 1'b0;
            a3_q    <= '0;
            wd3_q   <= '0;
            pc_we_q <= 1'b0;
            pc_wd_q <= '0;
            cnt_q   <= '0;
        end else begin
            we3_q   <= we3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            pc_we_q <= pc_we_d;
            pc_wd_q <= pc_wd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign GNT       = gnt;
    assign WE3       = we3_q;
    assign A3        = a3_q;
    assign WD3       = wd3_q;
    assign PC_WE     = pc_we_q;
    assign PC_WD     = pc_wd_q;
    assign CONFLICTS = cnt_q;

endmodule
